// File: rtl/mux_8_1_pkg.sv
// -----------------------------------------------------------------------------
// mux_8_1_pkg
// Shared constants and types for the round-robin scheduler that sits in front
// of the 8:1 mux datapath.
//   N_REQ        number of requesters (equals mux width)
//   SEL_W        mux select width
//   MAX_HOLD     default maximum grant length in cycles
//   HOLD_W       default hold-counter width
//   sched_state_t  scheduler state encoding
//   next_index   wrap-around increment of a requester index
// -----------------------------------------------------------------------------
package mux_8_1_pkg;

   localparam int N_REQ    = 8;
   localparam int SEL_W    = 3;
   localparam int MAX_HOLD = 15;
   localparam int HOLD_W   = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } sched_state_t;

   // N_REQ is a power of two, so the natural SEL_W-bit overflow gives mod-N_REQ.
   function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] idx);
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority encoder. Scans the request vector starting at
// ptr and wrapping modulo N_REQ; requesters set in mask are never selected.
// Ports:
//   req     in   N_REQ  request vector
//   ptr     in   SEL_W  index that has highest priority
//   mask    in   N_REQ  requesters excluded from this pick
//   valid   out  1      at least one unmasked request present
//   onehot  out  N_REQ  one-hot winner (zero when valid is low)
//   index   out  SEL_W  binary winner index (zero when valid is low)
// -----------------------------------------------------------------------------
module rr_priority_pick
   import mux_8_1_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic             valid,
   output logic [N_REQ-1:0] onehot,
   output logic [SEL_W-1:0] index
);

   logic [N_REQ-1:0] cand;
   logic [SEL_W-1:0] probe;

   assign cand = req & ~mask;

   // Walk ptr, ptr+1, ... and latch the first candidate found.
   always_comb begin
      valid = 1'b0;
      index = '0;
      probe = '0;
      for (int i = 0; i < N_REQ; i++) begin
         probe = ptr + SEL_W'(i);
         if (!valid && cand[probe]) begin
            valid = 1'b1;
            index = probe;
         end else begin
            valid = valid;
         end
      end
   end

   // Expand the binary winner into a one-hot vector.
   always_comb begin
      onehot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (valid && (index == SEL_W'(j))) begin
            onehot[j] = 1'b1;
         end else begin
            onehot[j] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_8_1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_8_1_rr_sched
// Round-robin scheduler that shares one 8:1 mux among 8 requesters. One owner
// is granted at a time and keeps the mux until it signals i_done, drops its
// request, or reaches the hold limit (forced release, flagged on o_timeout).
// On release the next owner is picked in the same cycle, so back-to-back
// grants have no idle gap.
// Ports:
//   i_clk       in   1      clock, rising edge
//   i_rst_n     in   1      asynchronous active-low reset
//   i_req       in   N_REQ  request vector, bit k = requester k
//   i_done      in   1      current owner releases the mux this cycle
//   o_grant     out  N_REQ  registered one-hot grant
//   o_sel_code  out  SEL_W  owner index, drives the mux select
//   o_en        out  1      mux enable, high while a grant is active
//   o_busy      out  1      equals |o_grant
//   o_timeout   out  1      one-cycle pulse after a hold-limit release
// -----------------------------------------------------------------------------
module mux_8_1_rr_sched
   import mux_8_1_pkg::*;
#(
   parameter int MAX_HOLD_P = MAX_HOLD,
   parameter int HOLD_W_P   = HOLD_W
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_done,
   output logic [N_REQ-1:0] o_grant,
   output logic [SEL_W-1:0] o_sel_code,
   output logic             o_en,
   output logic             o_busy,
   output logic             o_timeout
);

   localparam logic [HOLD_W_P-1:0] HOLD_LIMIT = HOLD_W_P'(MAX_HOLD_P - 1);
   localparam logic [HOLD_W_P-1:0] HOLD_SAT   = {HOLD_W_P{1'b1}};

   // Current state (owner is o_sel_code while in ST_GRANT).
   sched_state_t          state;
   logic [SEL_W-1:0]      ptr;
   logic [HOLD_W_P-1:0]   hold_cnt;

   // Next-state values.
   sched_state_t          state_nx;
   logic [SEL_W-1:0]      ptr_nx;
   logic [HOLD_W_P-1:0]   hold_nx;
   logic [N_REQ-1:0]      grant_nx;
   logic [SEL_W-1:0]      sel_nx;
   logic                  en_nx;
   logic                  busy_nx;
   logic                  timeout_nx;

   // Release decode for the current owner.
   logic                  owner_req;
   logic                  at_limit;
   logic                  release_now;
   logic                  limit_only;

   // Arbiter interface.
   logic [SEL_W-1:0]      pick_ptr;
   logic [N_REQ-1:0]      pick_mask;
   logic                  pick_valid;
   logic [N_REQ-1:0]      pick_onehot;
   logic [SEL_W-1:0]      pick_index;

   assign owner_req   = i_req[o_sel_code];
   assign at_limit    = (hold_cnt == HOLD_LIMIT);
   assign release_now = (state == ST_GRANT) && (i_done || !owner_req || at_limit);
   // A timeout is reported only when the hold limit is the sole release reason.
   assign limit_only  = at_limit && !i_done && owner_req;

   rr_priority_pick u_pick (
      .req    (i_req),
      .ptr    (pick_ptr),
      .mask   (pick_mask),
      .valid  (pick_valid),
      .onehot (pick_onehot),
      .index  (pick_index)
   );

   // Arbiter inputs: from the stored pointer when idle; when re-arbitrating on
   // release, start just past the owner and exclude the owner itself.
   always_comb begin
      pick_ptr  = ptr;
      pick_mask = '0;
      if (state == ST_GRANT) begin
         pick_ptr  = next_index(o_sel_code);
         pick_mask = o_grant;
      end else begin
         pick_ptr  = ptr;
         pick_mask = '0;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      hold_nx    = hold_cnt;
      grant_nx   = o_grant;
      sel_nx     = o_sel_code;
      en_nx      = o_en;
      busy_nx    = o_busy;
      timeout_nx = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nx = ST_GRANT;
               grant_nx = pick_onehot;
               sel_nx   = pick_index;
               en_nx    = 1'b1;
               busy_nx  = 1'b1;
               hold_nx  = '0;
            end else begin
               // o_sel_code keeps the last owner; it is a don't-care while o_en=0.
               state_nx = ST_IDLE;
               grant_nx = '0;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
            end
         end

         ST_GRANT: begin
            if (release_now) begin
               ptr_nx     = next_index(o_sel_code);
               timeout_nx = limit_only;
               if (pick_valid) begin
                  state_nx = ST_GRANT;
                  grant_nx = pick_onehot;
                  sel_nx   = pick_index;
                  en_nx    = 1'b1;
                  busy_nx  = 1'b1;
                  hold_nx  = '0;
               end else begin
                  state_nx = ST_IDLE;
                  grant_nx = '0;
                  en_nx    = 1'b0;
                  busy_nx  = 1'b0;
               end
            end else begin
               // Owner keeps the mux; request changes elsewhere do not preempt.
               if (hold_cnt != HOLD_SAT) begin
                  hold_nx = hold_cnt + HOLD_W_P'(1);
               end else begin
                  hold_nx = hold_cnt;
               end
            end
         end

         default: begin
            state_nx = ST_IDLE;
            grant_nx = '0;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
            hold_nx  = '0;
         end
      endcase
   end

   // State, pointer, hold counter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         hold_cnt   <= '0;
         o_grant    <= '0;
         o_sel_code <= '0;
         o_en       <= 1'b0;
         o_busy     <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         hold_cnt   <= hold_nx;
         o_grant    <= grant_nx;
         o_sel_code <= sel_nx;
         o_en       <= en_nx;
         o_busy     <= busy_nx;
         o_timeout  <= timeout_nx;
      end
   end

endmodule
